// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner tag
// and the latched memory request.
package mem_arb_pkg;

   localparam int MEM_DW = 32;
   localparam int MEM_AW = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP
   } arb_state_e;

   typedef enum logic {
      OWN_INST,
      OWN_DATA
   } arb_owner_e;

   // Field widths follow MEM_DW/MEM_AW; the top's width parameters default to these.
   typedef struct packed {
      logic                  we;
      logic [MEM_DW/8-1:0]   be;
      logic [MEM_AW-1:0]     addr;
      logic [MEM_DW-1:0]     wdata;
   } mem_req_t;

   // Instruction fetches are always full-word reads.
   function automatic mem_req_t fetch_req(input logic [MEM_AW-1:0] addr);
      mem_req_t r;
      r.we    = 1'b0;
      r.be    = '1;
      r.addr  = addr;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data has priority unless the data burst
// counter has reached its limit while a fetch is waiting.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4,
   parameter int CNT_W          = 3
) (
   input  logic             ireq_valid,
   input  logic             dreq_valid,
   input  logic [CNT_W-1:0] burst_cnt,
   output logic             grant_inst,
   output logic             grant_data
);

   logic starve;

   assign starve = (burst_cnt == CNT_W'(MAX_DATA_BURST));

   // NOTE: every output gets a default before the branches so no latch is inferred.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (dreq_valid && !(ireq_valid && starve)) begin
         grant_data = 1'b1;
      end else if (ireq_valid) begin
         grant_inst = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and the data stage; one transaction outstanding at a time.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = MEM_DW,
   parameter int ADDR_WIDTH     = MEM_AW,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ireq_valid,
   input  logic [ADDR_WIDTH-1:0]   ireq_addr,
   output logic                    ireq_ready,
   output logic                    iresp_valid,
   output logic [DATA_WIDTH-1:0]   iresp_rdata,
   input  logic                    dreq_valid,
   input  logic                    dreq_we,
   input  logic [DATA_WIDTH/8-1:0] dreq_be,
   input  logic [ADDR_WIDTH-1:0]   dreq_addr,
   input  logic [DATA_WIDTH-1:0]   dreq_wdata,
   output logic                    dreq_ready,
   output logic                    dresp_valid,
   output logic [DATA_WIDTH-1:0]   dresp_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);

   arb_state_e       state_q, state_d;
   arb_owner_e       owner_q;
   mem_req_t         req_q;
   logic [CNT_W-1:0] burst_cnt_q;
   logic             grant_inst, grant_data;
   logic             rsp_capture;

   mem_arb_pick #(
      .MAX_DATA_BURST (MAX_DATA_BURST),
      .CNT_W          (CNT_W)
   ) u_pick (
      .ireq_valid (ireq_valid),
      .dreq_valid (dreq_valid),
      .burst_cnt  (burst_cnt_q),
      .grant_inst (grant_inst),
      .grant_data (grant_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ready is suppressed during reset so no request is acknowledged without being latched.
   always_comb begin
      state_d     = state_q;
      ireq_ready  = 1'b0;
      dreq_ready  = 1'b0;
      mem_req     = 1'b0;
      rsp_capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst) begin
               ireq_ready = grant_inst;
               dreq_ready = grant_data;
               if (grant_inst || grant_data) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_req = 1'b1;
            if (mem_gnt) begin
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (mem_rvalid) begin
               rsp_capture = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= '0;
         owner_q     <= OWN_INST;
         burst_cnt_q <= '0;
         iresp_valid <= 1'b0;
         dresp_valid <= 1'b0;
         iresp_rdata <= '0;
         dresp_rdata <= '0;
      end else begin
         iresp_valid <= 1'b0;
         dresp_valid <= 1'b0;

         if (dreq_ready) begin
            req_q.we    <= dreq_we;
            req_q.be    <= dreq_be;
            req_q.addr  <= dreq_addr;
            req_q.wdata <= dreq_wdata;
            owner_q     <= OWN_DATA;
            // Only a run of data grants that actually blocked a fetch counts toward starvation.
            if (!ireq_valid) begin
               burst_cnt_q <= '0;
            end else if (burst_cnt_q != CNT_W'(MAX_DATA_BURST)) begin
               burst_cnt_q <= burst_cnt_q + 1'b1;
            end
         end else if (ireq_ready) begin
            req_q       <= fetch_req(ireq_addr);
            owner_q     <= OWN_INST;
            burst_cnt_q <= '0;
         end

         if (rsp_capture) begin
            if (owner_q == OWN_DATA) begin
               dresp_valid <= 1'b1;
               dresp_rdata <= req_q.we ? '0 : mem_rdata;
            end else begin
               iresp_valid <= 1'b1;
               iresp_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_we    = req_q.we;
   assign mem_be    = req_q.be;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small variable-latency memory
// responder; inputs change at posedge+1, outputs are sampled at negedge+1.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ireq_valid = 1'b0;
   logic [31:0] ireq_addr = '0;
   logic        ireq_ready, iresp_valid;
   logic [31:0] iresp_rdata;
   logic        dreq_valid = 1'b0;
   logic        dreq_we = 1'b0;
   logic [3:0]  dreq_be = '0;
   logic [31:0] dreq_addr = '0;
   logic [31:0] dreq_wdata = '0;
   logic        dreq_ready, dresp_valid;
   logic [31:0] dresp_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory responder controls
   int          gnt_wait = 0;
   int          rvalid_extra = 0;
   bit          ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;
   bit          spurious = 1'b0;
   bit          pend = 1'b0;
   int          pcnt = 0;
   logic [31:0] pval = '0;
   logic [31:0] gnt_addr = '0;

   mem_port_arbiter #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .MAX_DATA_BURST (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ireq_valid  (ireq_valid),
      .ireq_addr   (ireq_addr),
      .ireq_ready  (ireq_ready),
      .iresp_valid (iresp_valid),
      .iresp_rdata (iresp_rdata),
      .dreq_valid  (dreq_valid),
      .dreq_we     (dreq_we),
      .dreq_be     (dreq_be),
      .dreq_addr   (dreq_addr),
      .dreq_wdata  (dreq_wdata),
      .dreq_ready  (dreq_ready),
      .dresp_valid (dresp_valid),
      .dresp_rdata (dresp_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   // Memory: gnt after gnt_wait cycles of mem_req, rvalid rvalid_extra cycles after the gnt cycle.
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (spurious) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'h5555_5555;
         spurious   = 1'b0;
      end
      if (mem_gnt) begin
         pend = 1'b1;
         pcnt = rvalid_extra;
         pval = ovr_en ? ovr_val : mem_val(gnt_addr);
      end
      if (pend) begin
         if (pcnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pval;
            pend       = 1'b0;
         end else begin
            pcnt--;
         end
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
         if (gnt_wait > 0) begin
            gnt_wait--;
         end else begin
            mem_gnt  = 1'b1;
            gnt_addr = mem_addr;
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0004;
      @(negedge clk); #1;
      n_cmp++;
      if ({ireq_ready, dreq_ready, mem_req, iresp_valid, dresp_valid} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, want 00000", {ireq_ready, dreq_ready, mem_req, iresp_valid, dresp_valid});
      end
      n_cmp++;
      if ({mem_we, mem_be, mem_addr, mem_wdata, iresp_rdata, dresp_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: addr %h wdata %h irdata %h drdata %h, want all 0", mem_addr, mem_wdata, iresp_rdata, dresp_rdata);
      end
      n_cmp++;
      if (dut.burst_cnt_q !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_burst: got %0d, want 0", dut.burst_cnt_q);
      end
      @(posedge clk); #1;
      rst        = 1'b0;
      ireq_valid = 1'b0;
   endtask

   task automatic test_single_fetch();
      bit saw_d = 1'b0;
      ovr_en     = 1'b1;
      ovr_val    = 32'hDEAD_BEEF;
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0010;
      @(negedge clk); #1;
      saw_d |= dresp_valid;
      n_cmp++;
      if ({ireq_ready, dreq_ready, mem_req} !== 3'b100) begin
         n_bad++;
         $display("FAIL fetch_c0_ready: got %b, want 100", {ireq_ready, dreq_ready, mem_req});
      end
      @(posedge clk); #1;
      ireq_valid = 1'b0;
      @(negedge clk); #1;
      saw_d |= dresp_valid;
      n_cmp++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         n_bad++;
         $display("FAIL fetch_c1_mem: req %b we %b be %h addr %h, want 1 0 f 00000010", mem_req, mem_we, mem_be, mem_addr);
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      saw_d |= dresp_valid;
      n_cmp++;
      if ({mem_req, iresp_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL fetch_c2: req/iresp got %b, want 00", {mem_req, iresp_valid});
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      saw_d |= dresp_valid;
      n_cmp++;
      if ({iresp_valid, iresp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         n_bad++;
         $display("FAIL fetch_c3_resp: valid %b rdata %h, want 1 deadbeef", iresp_valid, iresp_rdata);
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      saw_d |= dresp_valid;
      n_cmp++;
      if ({iresp_valid, iresp_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
         n_bad++;
         $display("FAIL fetch_c4_hold: valid %b rdata %h, want 0 deadbeef", iresp_valid, iresp_rdata);
      end
      n_cmp++;
      if (saw_d !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_no_dresp: saw dresp_valid %b, want 0", saw_d);
      end
      @(posedge clk); #1;
      ovr_en = 1'b0;
   endtask

   task automatic test_back_pressure();
      bit done = 1'b0;
      gnt_wait   = 5;
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0044;
      @(negedge clk); #1;
      n_cmp++;
      if (ireq_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_accept: ireq_ready %b, want 1", ireq_ready);
      end
      @(posedge clk); #1;
      ireq_valid = 1'b0;
      dreq_valid = 1'b1;
      dreq_we    = 1'b0;
      dreq_be    = 4'hF;
      dreq_addr  = 32'h0000_0200;
      dreq_wdata = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); #1;
         n_cmp++;
         if ({mem_req, mem_gnt, mem_we, mem_be, mem_addr, ireq_ready, dreq_ready, iresp_valid} !==
             {2'b10, 1'b0, 4'hF, 32'h44, 3'b000}) begin
            n_bad++;
            $display("FAIL bp_stall_c%0d: req %b gnt %b be %h addr %h rdy %b%b iresp %b", c, mem_req, mem_gnt, mem_be, mem_addr, ireq_ready, dreq_ready, iresp_valid);
         end
         @(posedge clk); #1;
         if (c == 1) spurious = 1'b1;
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({mem_req, mem_gnt, dreq_ready} !== 3'b110) begin
         n_bad++;
         $display("FAIL bp_gnt: req/gnt/dready %b, want 110", {mem_req, mem_gnt, dreq_ready});
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      n_cmp++;
      if ({dreq_ready, iresp_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL bp_wait: dready/iresp %b, want 00", {dreq_ready, iresp_valid});
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      n_cmp++;
      if ({iresp_valid, iresp_rdata, dreq_ready} !== {1'b1, mem_val(32'h44), 1'b1}) begin
         n_bad++;
         $display("FAIL bp_resp: iresp %b rdata %h dready %b, want 1 %h 1", iresp_valid, iresp_rdata, dreq_ready, mem_val(32'h44));
      end
      @(posedge clk); #1;
      dreq_valid = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk); #1;
         if (dresp_valid) begin
            done = 1'b1;
            n_cmp++;
            if (dresp_rdata !== mem_val(32'h200)) begin
               n_bad++;
               $display("FAIL bp_load_data: got %h, want %h", dresp_rdata, mem_val(32'h200));
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_load_timeout: got no dresp_valid, want one");
      end
   endtask

   task automatic test_store();
      bit          acc = 1'b0, seen = 1'b0, done = 1'b0, stray = 1'b0;
      logic [68:0] f = '0;
      logic [31:0] rd = 'x;
      dreq_valid = 1'b1;
      dreq_we    = 1'b1;
      dreq_be    = 4'b0011;
      dreq_addr  = 32'h0000_0100;
      dreq_wdata = 32'h1234_5678;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk); #1;
         if (dreq_ready) acc = 1'b1;
         if (mem_req && mem_gnt) begin
            seen = 1'b1;
            f    = {mem_we, mem_be, mem_addr, mem_wdata};
         end
         if (iresp_valid) stray = 1'b1;
         if (dresp_valid) begin
            done = 1'b1;
            rd   = dresp_rdata;
         end
         @(posedge clk); #1;
         if (acc) dreq_valid = 1'b0;
      end
      n_cmp++;
      if ({done, seen} !== 2'b11) begin
         n_bad++;
         $display("FAIL store_timeout: done/seen %b, want 11", {done, seen});
      end
      n_cmp++;
      if (f !== {1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
         n_bad++;
         $display("FAIL store_fields: got %h, want %h", f, {1'b1, 4'b0011, 32'h100, 32'h1234_5678});
      end
      n_cmp++;
      if ({stray, rd} !== 33'h0) begin
         n_bad++;
         $display("FAIL store_resp: iresp stray %b rdata %h, want 0 00000000", stray, rd);
      end
      dreq_we = 1'b0;
   endtask

   task automatic test_burst();
      int ng = 0, ni = 0, nd = 0;
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0400;
      dreq_valid = 1'b1;
      dreq_we    = 1'b0;
      dreq_be    = 4'hF;
      dreq_addr  = 32'h0000_0500;
      for (int c = 0; c < 300 && ng < 10; c++) begin
         @(negedge clk); #1;
         if (iresp_valid) ni++;
         if (dresp_valid) nd++;
         if (ireq_ready || dreq_ready) begin
            n_cmp++;
            if ({ireq_ready, dreq_ready, dut.burst_cnt_q} !== {((ng % 5) == 4) ? 2'b10 : 2'b01, 3'(ng % 5)}) begin
               n_bad++;
               $display("FAIL burst_grant%0d: rdy i/d %b%b cnt %0d, want %s cnt %0d", ng, ireq_ready, dreq_ready, dut.burst_cnt_q, ((ng % 5) == 4) ? "I" : "D", ng % 5);
            end
            ng++;
         end
         @(posedge clk); #1;
      end
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         if (iresp_valid) ni++;
         if (dresp_valid) nd++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if ({ng, ni, nd} !== {32'd10, 32'd2, 32'd8}) begin
         n_bad++;
         $display("FAIL burst_counts: grants %0d iresp %0d dresp %0d, want 10 2 8", ng, ni, nd);
      end
      n_cmp++;
      if (dut.burst_cnt_q !== 3'd0) begin
         n_bad++;
         $display("FAIL burst_cnt_after_i: got %0d, want 0", dut.burst_cnt_q);
      end
   endtask

   task automatic test_data_only();
      int idx = 0, rsp = 0;
      bit acc;
      ireq_valid = 1'b0;
      dreq_valid = 1'b1;
      dreq_we    = 1'b0;
      dreq_be    = 4'hF;
      dreq_addr  = 32'h0000_0300;
      for (int c = 0; c < 200 && rsp < 10; c++) begin
         @(negedge clk); #1;
         acc = dreq_ready;
         if (dreq_ready) begin
            n_cmp++;
            if (dut.burst_cnt_q !== 3'd0) begin
               n_bad++;
               $display("FAIL donly_burst%0d: got %0d, want 0", idx, dut.burst_cnt_q);
            end
         end
         if (dresp_valid) begin
            n_cmp++;
            if (dresp_rdata !== mem_val(32'h300 + 32'(4 * rsp))) begin
               n_bad++;
               $display("FAIL donly_load%0d: got %h, want %h", rsp, dresp_rdata, mem_val(32'h300 + 32'(4 * rsp)));
            end
            rsp++;
         end
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 10) dreq_addr = 32'h300 + 32'(4 * idx);
            else          dreq_valid = 1'b0;
         end
      end
      n_cmp++;
      if (rsp !== 10) begin
         n_bad++;
         $display("FAIL donly_count: got %0d responses, want 10", rsp);
      end
   endtask

   task automatic test_reset_mid();
      bit acc = 1'b0, gnt_seen = 1'b0, stray = 1'b0, done = 1'b0;
      rvalid_extra = 1;
      ovr_en       = 1'b1;
      ovr_val      = 32'hAAAA_AAAA;
      ireq_valid   = 1'b1;
      ireq_addr    = 32'h0000_0080;
      for (int c = 0; c < 10 && !gnt_seen; c++) begin
         @(negedge clk); #1;
         if (ireq_ready) acc = 1'b1;
         if (mem_req && mem_gnt) gnt_seen = 1'b1;
         @(posedge clk); #1;
         if (acc) ireq_valid = 1'b0;
      end
      n_cmp++;
      if (gnt_seen !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_gnt: got no grant, want one");
      end
      rst = 1'b1;
      @(negedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({mem_req, mem_addr, iresp_valid, iresp_rdata, mem_rvalid} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
         n_bad++;
         $display("FAIL rstmid_clear: req %b addr %h iresp %b rdata %h late_rvalid %b", mem_req, mem_addr, iresp_valid, iresp_rdata, mem_rvalid);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk); #1;
         if (iresp_valid || dresp_valid) stray = 1'b1;
      end
      n_cmp++;
      if (stray !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_no_resp: saw resp_valid %b, want 0", stray);
      end
      @(posedge clk); #1;
      rvalid_extra = 0;
      ovr_en       = 1'b0;
      ireq_valid   = 1'b1;
      ireq_addr    = 32'h0000_0090;
      @(negedge clk); #1;
      n_cmp++;
      if (ireq_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_idle: ireq_ready %b, want 1", ireq_ready);
      end
      @(posedge clk); #1;
      ireq_valid = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk); #1;
         if (iresp_valid) begin
            done = 1'b1;
            n_cmp++;
            if (iresp_rdata !== mem_val(32'h90)) begin
               n_bad++;
               $display("FAIL rstmid_next_data: got %h, want %h", iresp_rdata, mem_val(32'h90));
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_next_timeout: got no iresp_valid, want one");
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_pressure();
      test_store();
      test_burst();
      test_data_only();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the fetch requester (instruction reads) and the memory-stage requester (data loads/stores) of the 5-stage core.
- Data has fixed priority over fetch. A starvation guard forces a fetch grant after a bounded run of data grants.
- At most one transaction is outstanding at a time. The block sits between if_stage/mem_stage and the unified memory model.

Parameters:
- DATA_WIDTH, 32, width of data words and of all rdata/wdata buses.
- ADDR_WIDTH, 32, byte address width.
- MAX_DATA_BURST, 4, number of consecutive data grants allowed while a fetch is pending; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ireq_valid  in  1  fetch request valid.
- ireq_addr  in  ADDR_WIDTH  fetch byte address.
- ireq_ready  out  1  fetch request accepted this cycle.
- iresp_valid  out  1  fetch read data valid, one-cycle pulse.
- iresp_rdata  out  DATA_WIDTH  fetch read data.
- dreq_valid  in  1  data request valid.
- dreq_we  in  1  1 = store, 0 = load.
- dreq_be  in  DATA_WIDTH/8  byte enables for stores.
- dreq_addr  in  ADDR_WIDTH  data byte address.
- dreq_wdata  in  DATA_WIDTH  store data.
- dreq_ready  out  1  data request accepted this cycle.
- dresp_valid  out  1  data completion pulse, for loads and stores.
- dresp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset clears all of the following to 0: state, latched request, owner, starvation counter, and every output.
- Requester rules: requesters hold valid and all request fields stable until ready. ready is a one-cycle pulse, asserted only in IDLE.
- States are IDLE, ISSUE and WAIT_RESP.
- IDLE, winner selection:
  - If only one requester is valid, it wins.
  - If both are valid, data wins, unless burst_cnt == MAX_DATA_BURST; then fetch wins.
- IDLE, accepting the winner:
  - Latch the winner's fields and record the owner.
  - Pulse the winner's ready for one cycle, then go to ISSUE.
  - A fetch request latches we=0 and be=all-ones.
  - With no valid requester, stay in IDLE.
- burst_cnt update on each accepted request:
  - On a data grant with ireq_valid=1: increment, saturating at MAX_DATA_BURST.
  - On a fetch grant, or a data grant with ireq_valid=0: reset to 0.
- ISSUE:
  - mem_req=1 and the mem_* outputs are driven from the latched request.
  - The latched request stays stable until mem_gnt. On mem_gnt, go to WAIT_RESP; mem_req drops in the next cycle.
  - mem_rvalid seen in ISSUE is ignored.
- WAIT_RESP:
  - On mem_rvalid, register the response to the owner, then return to IDLE.
  - The owner's resp_valid pulses in the next cycle.
  - For a load or fetch, rdata = mem_rdata. For a store, dresp_rdata = 0.
  - The non-owner's resp_valid stays 0.
- Latency, with gnt in the same cycle as req and rvalid one cycle after gnt:
  - Cycle 0: ready. Cycle 1: mem_req/gnt. Cycle 2: rvalid, and the block is back in IDLE.
  - Cycle 3: resp_valid, concurrent with the next ready.
  - Peak throughput is one transaction per 3 cycles.
- Idle outputs: mem_req=0 outside ISSUE. When not in ISSUE, mem_* fields hold the last latched values.
- Non-pulsed outputs: resp_rdata holds its last value when resp_valid=0.
- Reset mid-transaction:
  - Any state returns to IDLE and mem_req drops in the next cycle.
  - A late mem_rvalid after reset is ignored, because it is only sampled in WAIT_RESP.
  - No resp_valid is produced for the abandoned transaction.
- No address checking: misaligned addresses pass through unmodified. Alignment checking is the requester's job.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_e enum: IDLE, ISSUE, WAIT_RESP.
  - arb_owner_e enum: OWN_INST, OWN_DATA.
  - mem_req_t struct: we, be, addr, wdata.
- Sub-module mem_arb_pick: combinational winner selection. Inputs: ireq_valid, dreq_valid, burst_cnt, MAX_DATA_BURST. Outputs: grant_inst, grant_data.
- The FSM, latch registers and burst counter live in the top module.

Test Plan:
- Single fetch:
  - Stimulus: ireq addr 0x0000_0010; memory gnt immediately, rdata 0xDEAD_BEEF.
  - Required: ireq_ready in cycle 0; mem_req with addr 0x10, we=0 in cycle 1; iresp_valid with 0xDEADBEEF in cycle 3; dresp_valid never asserted.
- Store:
  - Stimulus: dreq we=1, be=4'b0011, addr 0x100, wdata 0x1234_5678.
  - Required: mem_we=1, mem_be=0011, mem_wdata 0x12345678; dresp_valid pulse with rdata 0.
- Simultaneous requests, MAX_DATA_BURST=4, both valid continuously:
  - Required grant order: D,D,D,D,I,D,D,D,D,I…
  - burst_cnt returns to 0 after each I grant.
- Back-pressure:
  - Stimulus: mem_gnt low for 5 cycles.
  - Required: mem_req and all fields stable for 5 cycles; no ready pulse to either requester until the response.
  - Also: a spurious mem_rvalid during ISSUE is ignored.
- Reset mid-transaction:
  - Stimulus: rst for 1 cycle in WAIT_RESP, then mem_rvalid 0xAAAA_AAAA.
  - Required: no resp_valid; state IDLE; next fetch completes normally.
- Data only, ireq_valid=0:
  - Stimulus: 10 back-to-back loads.
  - Required: burst_cnt stays 0; every load returns the correct rdata in order.
